// File: rtl/msg_queue_pkg.sv
// Shared constants for the message channel and its receive-side queue.
package msg_queue_pkg;

  localparam int MSG_LEN = 8;

  // Occupancy counter width: must represent 0..depth inclusive.
  function automatic int level_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/msg_queue_ram.sv
// Depth x MsgLen storage: synchronous write, asynchronous read so the head
// entry falls through to the consumer without a cycle of read latency.
module msg_queue_ram #(
  parameter int MsgLen = 8,
  parameter int Depth  = 4,
  parameter int PtrW   = $clog2(Depth)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [PtrW-1:0]   wr_addr,
  input  logic [MsgLen-1:0] wr_data,
  input  logic [PtrW-1:0]   rd_addr,
  output logic [MsgLen-1:0] rd_data
);

  logic [MsgLen-1:0] mem_q [Depth];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/msg_queue.sv
// First-word-fall-through message FIFO with sticky overflow flag and a
// saturating count of messages dropped while the queue was full.
module msg_queue
  import msg_queue_pkg::*;
#(
  parameter int MsgLen   = MSG_LEN,
  parameter int Depth    = 4,
  parameter int DropCntW = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_trigger,
  input  logic [MsgLen-1:0]          in_msg,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [MsgLen-1:0]          out_msg,
  output logic [level_w(Depth)-1:0]  level,
  output logic                       full,
  output logic                       empty,
  output logic                       ovf,
  input  logic                       ovf_clr,
  output logic [DropCntW-1:0]        drop_count
);

  localparam int PtrW = $clog2(Depth);
  localparam int LvlW = level_w(Depth);

  logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0]     level_q, level_d;
  logic                ovf_q, ovf_d;
  logic [DropCntW-1:0] drop_cnt_q, drop_cnt_d;
  logic [MsgLen-1:0]   rd_data;
  logic                push, pop, drop;

  assign empty     = (level_q == '0);
  assign full      = (level_q == LvlW'(Depth));
  assign out_valid = !empty;
  assign pop       = out_valid & out_ready;
  // A full queue still accepts a message when the head leaves in the same cycle.
  assign push      = in_trigger & (!full | pop);
  assign drop      = in_trigger & full & !pop;

  always_comb begin
    wr_ptr_d   = wr_ptr_q + PtrW'(push);
    rd_ptr_d   = rd_ptr_q + PtrW'(pop);
    level_d    = level_q + LvlW'(push) - LvlW'(pop);
    ovf_d      = ovf_q;
    drop_cnt_d = drop_cnt_q;
    // Clear wins over a coincident drop; that drop goes uncounted.
    if (ovf_clr) begin
      ovf_d      = 1'b0;
      drop_cnt_d = '0;
    end else if (drop) begin
      ovf_d = 1'b1;
      if (!(&drop_cnt_q)) begin
        drop_cnt_d = drop_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      ovf_q      <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      ovf_q      <= ovf_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  msg_queue_ram #(
    .MsgLen (MsgLen),
    .Depth  (Depth),
    .PtrW   (PtrW)
  ) u_ram (
    .clk     (clk),
    .we      (push & !rst),
    .wr_addr (wr_ptr_q),
    .wr_data (in_msg),
    .rd_addr (rd_ptr_q),
    .rd_data (rd_data)
  );

  // Storage is uninitialised, so mask the head while the queue is empty.
  assign out_msg    = out_valid ? rd_data : '0;
  assign level      = level_q;
  assign ovf        = ovf_q;
  assign drop_count = drop_cnt_q;

endmodule

// File: tb/tb_msg_queue.sv
// Directed vector table plus corner-case sequences and a randomised run
// against a queue reference model for msg_queue (Depth=4, MsgLen=8).
module tb_msg_queue;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_trigger;
  logic [7:0] in_msg;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_msg;
  logic [2:0] level;
  logic       full;
  logic       empty;
  logic       ovf;
  logic       ovf_clr;
  logic [7:0] drop_count;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  msg_queue #(.MsgLen(8), .Depth(4), .DropCntW(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_trigger (in_trigger),
    .in_msg     (in_msg),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_msg    (out_msg),
    .level      (level),
    .full       (full),
    .empty      (empty),
    .ovf        (ovf),
    .ovf_clr    (ovf_clr),
    .drop_count (drop_count)
  );

  typedef struct {
    logic       trig;
    logic [7:0] msg;
    logic       rdy;
    logic       clr;
    logic       rst;
    logic       e_valid;
    logic [7:0] e_msg;
    logic [2:0] e_lvl;
    logic       e_ovf;
    logic [7:0] e_drop;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic trig, input logic [7:0] msg, input logic rdy,
                              input logic clr, input logic r, input logic e_valid,
                              input logic [7:0] e_msg, input logic [2:0] e_lvl,
                              input logic e_ovf, input logic [7:0] e_drop);
    vec_t v;
    v = '{trig, msg, rdy, clr, r, e_valid, e_msg, e_lvl, e_ovf, e_drop};
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive inputs for one cycle, then sample 1 time unit after the edge.
  task automatic step(input logic trig, input logic [7:0] msg, input logic rdy,
                      input logic clr, input logic r);
    in_trigger = trig;
    in_msg     = msg;
    out_ready  = rdy;
    ovf_clr    = clr;
    rst        = r;
    @(posedge clk);
    #1;
  endtask

  logic [7:0] model_q[$];
  logic [7:0] model_drops;
  logic       model_ovf;

  initial begin
    rst = 1'b1; in_trigger = 1'b0; in_msg = '0; out_ready = 1'b0; ovf_clr = 1'b0;
    @(posedge clk); @(posedge clk); #1;

    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_msg",   32'(out_msg),   32'd0);
    chk("rst_level", 32'(level),     32'd0);
    chk("rst_empty", 32'(empty),     32'd1);
    chk("rst_full",  32'(full),      32'd0);
    chk("rst_ovf",   32'(ovf),       32'd0);
    chk("rst_drop",  32'(drop_count), 32'd0);

    //  trig msg    rdy  clr  rst  valid emsg   lvl ovf drop
    add(1, 8'h11, 0, 0, 0,  1, 8'h11, 1, 0, 0);
    add(0, 8'h00, 1, 0, 0,  0, 8'h00, 0, 0, 0);
    add(1, 8'h01, 0, 0, 0,  1, 8'h01, 1, 0, 0);
    add(1, 8'h02, 0, 0, 0,  1, 8'h01, 2, 0, 0);
    add(1, 8'h03, 0, 0, 0,  1, 8'h01, 3, 0, 0);
    add(1, 8'h04, 0, 0, 0,  1, 8'h01, 4, 0, 0);
    add(1, 8'h05, 0, 0, 0,  1, 8'h01, 4, 1, 1);  // dropped
    add(0, 8'h00, 1, 0, 0,  1, 8'h02, 3, 1, 1);
    add(0, 8'h00, 1, 0, 0,  1, 8'h03, 2, 1, 1);
    add(0, 8'h00, 1, 0, 0,  1, 8'h04, 1, 1, 1);
    add(0, 8'h00, 1, 0, 0,  0, 8'h00, 0, 1, 1);
    add(0, 8'h00, 0, 1, 0,  0, 8'h00, 0, 0, 0);
    add(1, 8'hA1, 0, 0, 0,  1, 8'hA1, 1, 0, 0);
    add(1, 8'hA2, 0, 0, 0,  1, 8'hA1, 2, 0, 0);
    add(1, 8'hA3, 0, 0, 0,  1, 8'hA1, 3, 0, 0);
    add(1, 8'hA4, 0, 0, 0,  1, 8'hA1, 4, 0, 0);
    add(1, 8'hAA, 1, 0, 0,  1, 8'hA2, 4, 0, 0);  // push+pop while full
    add(0, 8'h00, 1, 0, 0,  1, 8'hA3, 3, 0, 0);
    add(0, 8'h00, 1, 0, 0,  1, 8'hA4, 2, 0, 0);
    add(0, 8'h00, 1, 0, 0,  1, 8'hAA, 1, 0, 0);
    add(0, 8'h00, 1, 0, 0,  0, 8'h00, 0, 0, 0);
    add(1, 8'h31, 0, 0, 0,  1, 8'h31, 1, 0, 0);
    add(1, 8'h32, 0, 0, 0,  1, 8'h31, 2, 0, 0);
    add(1, 8'h33, 0, 0, 0,  1, 8'h31, 3, 0, 0);
    add(1, 8'h77, 0, 0, 1,  0, 8'h00, 0, 0, 0);  // reset with trigger
    add(0, 8'h00, 0, 0, 0,  0, 8'h00, 0, 0, 0);
    add(1, 8'hB1, 0, 0, 0,  1, 8'hB1, 1, 0, 0);
    add(1, 8'hB2, 0, 0, 0,  1, 8'hB1, 2, 0, 0);
    add(1, 8'hB3, 0, 0, 0,  1, 8'hB1, 3, 0, 0);
    add(1, 8'hB4, 0, 0, 0,  1, 8'hB1, 4, 0, 0);
    add(1, 8'h55, 0, 1, 0,  1, 8'hB1, 4, 0, 0);  // clear beats drop
    add(1, 8'h56, 0, 0, 0,  1, 8'hB1, 4, 1, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      int f0;
      f0 = fails;
      step(vecs[i].trig, vecs[i].msg, vecs[i].rdy, vecs[i].clr, vecs[i].rst);
      chk($sformatf("v%0d_valid", i), 32'(out_valid), 32'(vecs[i].e_valid));
      if (vecs[i].e_valid || vecs[i].rst)
        chk($sformatf("v%0d_msg", i), 32'(out_msg), 32'(vecs[i].e_msg));
      chk($sformatf("v%0d_level", i), 32'(level), 32'(vecs[i].e_lvl));
      chk($sformatf("v%0d_full", i),  32'(full),  32'(vecs[i].e_lvl == 3'd4));
      chk($sformatf("v%0d_empty", i), 32'(empty), 32'(vecs[i].e_lvl == 3'd0));
      chk($sformatf("v%0d_ovf", i),   32'(ovf),   32'(vecs[i].e_ovf));
      chk($sformatf("v%0d_drop", i),  32'(drop_count), 32'(vecs[i].e_drop));
      $display("[TB] vec %0d trig=%0d msg=%02h rdy=%0d clr=%0d rst=%0d -> valid=%0d out=%02h lvl=%0d ovf=%0d drop=%0d%s",
               i, vecs[i].trig, vecs[i].msg, vecs[i].rdy, vecs[i].clr, vecs[i].rst,
               out_valid, out_msg, level, ovf, drop_count, (fails == f0) ? "" : " (bad)");
    end

    // Saturation: queue is full and stalled with one drop already counted.
    for (int i = 0; i < 300; i++) step(1, 8'(i), 0, 0, 0);
    chk("sat_drop",  32'(drop_count), 32'hFF);
    chk("sat_ovf",   32'(ovf),        32'd1);
    chk("sat_level", 32'(level),      32'd4);
    chk("sat_head",  32'(out_msg),    32'hB1);
    $display("[TB] saturate: 300 stalled triggers -> drop=%0d ovf=%0d", drop_count, ovf);
    step(0, 8'h00, 0, 1, 0);
    chk("clr_drop", 32'(drop_count), 32'd0);
    chk("clr_ovf",  32'(ovf),        32'd0);
    $display("[TB] ovf_clr -> drop=%0d ovf=%0d", drop_count, ovf);

    // Randomised run against a reference queue.
    step(0, 8'h00, 0, 0, 1);
    model_drops = '0;
    model_ovf   = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      logic       t, r, pop_m, push_m;
      logic [7:0] m;
      t = 1'($urandom_range(0, 1));
      r = 1'($urandom_range(0, 1));
      m = 8'($urandom_range(0, 255));
      chk("rnd_valid", 32'(out_valid), 32'(model_q.size() != 0));
      if (model_q.size() != 0) chk("rnd_msg", 32'(out_msg), 32'(model_q[0]));
      chk("rnd_level", 32'(level), 32'(model_q.size()));
      pop_m  = (model_q.size() != 0) && r;
      push_m = t && ((model_q.size() != 4) || pop_m);
      if (t && !push_m) begin
        model_ovf = 1'b1;
        if (model_drops != 8'hFF) model_drops = model_drops + 8'd1;
      end
      step(t, m, r, 0, 0);
      if (pop_m)  void'(model_q.pop_front());
      if (push_m) model_q.push_back(m);
    end
    chk("rnd_drop", 32'(drop_count), 32'(model_drops));
    chk("rnd_ovf",  32'(ovf),        32'(model_ovf));
    $display("[TB] random: 10000 cycles, model drops=%0d dut drops=%0d", model_drops, drop_count);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
